ring_round_robin_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters. A one-hot rotating priority pointer behaves as a ring counter: it advances one position past each requester it services. The block sits in front of a shared datapath and issues registered one-hot grants. A per-grant hold limit prevents starvation, and the pointer can be preset for deterministic start-up.

---
 rtl/ring_round_robin_arbiter.sv | 71 +++++++
 tb/tb_ring_round_robin_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ring_round_robin_arbiter.sv
// ring_round_robin_arbiter: N-way round-robin arbiter with rotating one-hot pointer, hold limit and pointer preset
module ring_round_robin_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 preset_en,
  input  logic [N-1:0]         preset,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [7:0]           hold_cnt,
  output logic                 expired,
  output logic                 cfg_err
);
  localparam int W = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [N-1:0] ptr;
  logic [W-1:0] ptr_id, win_id;
  logic [2*N-1:0] dbl;
  logic [W:0] off, sum;
  assign grant_valid = |grant;
  always_comb begin
    ptr_id = '0;
    for (int i = 0; i < N; i++) ptr_id = ptr[i] ? W'(i) : ptr_id;
  end
  // rotate req so the pointer position lands at bit 0, then the lowest set bit is the winner's offset
  always_comb begin
    dbl = {req, req} >> ptr_id;
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = dbl[k] ? (W+1)'(k) : off;
    sum = {1'b0, ptr_id} + off;
    win_id = W'(sum >= (W+1)'(N) ? sum - (W+1)'(N) : sum);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= N'(1);
      grant <= '0;
      grant_id <= '0;
      hold_cnt <= '0;
      expired <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      expired <= 1'b0;
      cfg_err <= preset_en && (state == GRANT || !$onehot(preset));
      if (state == IDLE) begin
        if (preset_en) begin
          if ($onehot(preset)) ptr <= preset;
        end else if (|req) begin
          state <= GRANT;
          grant <= N'(1) << win_id;
          grant_id <= win_id;
          hold_cnt <= 8'd1;
        end
      end else if (req[grant_id] && hold_cnt < 8'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else begin
        state <= IDLE;
        grant <= '0;
        grant_id <= '0;
        hold_cnt <= '0;
        ptr <= {grant[N-2:0], grant[N-1]};
        expired <= req[grant_id];
      end
    end
  end
endmodule

// File: tb/tb_ring_round_robin_arbiter.sv
// tb_ring_round_robin_arbiter: directed vectors checked every cycle against an index-based reference model
module tb_ring_round_robin_arbiter;
  localparam int N = 4;
  localparam int MH = 8;
  logic clk = 0;
  logic rst = 0;
  logic preset_en = 0;
  logic [N-1:0] req = '0;
  logic [N-1:0] preset = '0;
  logic [N-1:0] grant;
  logic grant_valid, expired, cfg_err;
  logic [1:0] grant_id;
  logic [7:0] hold_cnt;
  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  int m_own = -1;
  int m_hold = 0;
  bit m_exp = 0;
  bit m_cfg = 0;
  ring_round_robin_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .preset_en(preset_en), .preset(preset),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .hold_cnt(hold_cnt), .expired(expired), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(logic r, logic [N-1:0] rq, logic pen = 1'b0, logic [N-1:0] pre = '0);
    rst = r;
    req = rq;
    preset_en = pen;
    preset = pre;
    if (r) begin
      m_ptr = 0;
      m_own = -1;
      m_hold = 0;
      m_exp = 0;
      m_cfg = 0;
    end else if (m_own < 0) begin
      m_exp = 0;
      m_cfg = pen && $countones(pre) != 1;
      if (pen) begin
        if ($countones(pre) == 1)
          for (int i = 0; i < N; i++) if (pre[i]) m_ptr = i;
      end else if (rq != 0) begin
        m_hold = 1;
        for (int k = 0; k < N; k++) if (m_own < 0 && rq[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      end
    end else begin
      m_cfg = pen;
      m_exp = 0;
      if (rq[m_own] && m_hold < MH) m_hold++;
      else begin
        m_exp = rq[m_own];
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        m_hold = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("grant", grant, m_own < 0 ? 0 : 1 << m_own);
    chk("grant_valid", grant_valid, m_own >= 0);
    chk("grant_id", grant_id, m_own < 0 ? 0 : m_own);
    chk("hold_cnt", hold_cnt, m_hold);
    chk("expired", expired, m_exp);
    chk("cfg_err", cfg_err, m_cfg);
  endtask
  initial begin
    cyc(1, '0);
    cyc(1, '0);
    chk("reset grant", grant, 0);
    chk("reset hold", hold_cnt, 0);
    for (int c = 1; c <= 37; c++) begin
      cyc(0, 4'b1111);
      if (c == 1) chk("t1 first grant", grant, 4'b0001);
      if (c == 8) chk("t1 hold 8", hold_cnt, 8);
      if (c == 9) chk("t1 expired", expired, 1);
      if (c == 9) chk("t1 bubble", grant, 0);
      if (c == 10) chk("t1 second grant", grant, 4'b0010);
      if (c == 28) chk("t1 fourth grant", grant, 4'b1000);
      if (c == 37) chk("t1 wrap grant", grant, 4'b0001);
    end
    cyc(0, '0);
    cyc(1, '0);
    for (int c = 1; c <= 3; c++) begin
      cyc(0, 4'b0100);
      if (c == 1) chk("t2 grant", grant, 4'b0100);
      if (c == 3) chk("t2 hold 3", hold_cnt, 3);
    end
    cyc(0, '0);
    chk("t2 released", grant, 0);
    chk("t2 no expired", expired, 0);
    cyc(0, 4'b1011);
    chk("t2 ptr at 3", grant, 4'b1000);
    cyc(0, '0);
    cyc(1, '0);
    cyc(0, 4'b1001, 1'b1, 4'b1000);
    chk("t3 no grant on preset", grant, 0);
    cyc(0, 4'b1001);
    chk("t3 preset grant", grant, 4'b1000);
    chk("t3 preset id", grant_id, 3);
    cyc(0, 4'b0001);
    chk("t3 release", grant, 0);
    cyc(0, 4'b0001);
    chk("t3 wrap grant", grant, 4'b0001);
    cyc(0, '0);
    cyc(0, '0, 1'b1, 4'b0110);
    chk("t4 bad preset err", cfg_err, 1);
    cyc(0, 4'b1111);
    chk("t4 ptr unchanged", grant, 4'b0010);
    chk("t4 err cleared", cfg_err, 0);
    cyc(0, 4'b1111, 1'b1, 4'b0001);
    chk("t4 busy preset err", cfg_err, 1);
    chk("t4 grant kept", grant, 4'b0010);
    chk("t4 hold 2", hold_cnt, 2);
    cyc(0, '0);
    cyc(1, '0);
    for (int c = 1; c <= 20; c++) begin
      cyc(0, 4'b0100);
      if (c == 9) chk("t5 expired", expired, 1);
      if (c == 10) chk("t5 regrant hold", hold_cnt, 1);
      if (c == 18) chk("t5 expired again", expired, 1);
      if (c == 19) chk("t5 regrant", grant, 4'b0100);
    end
    cyc(0, '0);
    cyc(1, '0);
    for (int c = 1; c <= 5; c++) cyc(0, 4'b1000);
    chk("t6 hold 5", hold_cnt, 5);
    cyc(1, 4'b0010);
    chk("t6 reset grant", grant, 0);
    chk("t6 reset hold", hold_cnt, 0);
    chk("t6 reset no expired", expired, 0);
    cyc(0, 4'b1010);
    chk("t6 grant after reset", grant, 4'b0010);
    cyc(0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
